// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared lane indices, sideband type and width helpers for the FFT butterfly
package fft_pkg;

  localparam int A_RE = 0;
  localparam int A_IM = 1;
  localparam int B_RE = 2;
  localparam int B_IM = 3;

  localparam int X_RE = 0;
  localparam int X_IM = 1;
  localparam int Y_RE = 2;
  localparam int Y_IM = 3;

  localparam int W_RE = 0;
  localparam int W_IM = 1;

  // Real/imaginary slots of a two-lane complex pair
  localparam int C_RE = 0;
  localparam int C_IM = 1;

  typedef struct packed {
    logic valid;
    logic last;
  } beat_ctl_t;

  // Half an LSB of the Q1.(w-1) product scaling, for round-half-up
  function automatic int round_offset(input int w);
    return 1 << (w - 2);
  endfunction

  function automatic bit width_is_legal(input int w);
    return (w == 8) || (w == 16);
  endfunction

endpackage

// File: rtl/axi_ctr_intrf.sv
// rtl/axi_ctr_intrf.sv - valid/ready/last control handshake shared by stream ports
interface axi_ctr_intrf;
  logic tvalid;
  logic tready;
  logic tlast;

  modport s_axis (input tvalid, input tlast, output tready);
  modport m_axis (output tvalid, output tlast, input tready);
endinterface

// File: rtl/fft_cmul.sv
// rtl/fft_cmul.sv - twiddle multiply: S1 registers products, S2 registers rounded/saturated t
module fft_cmul
  import fft_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [0:1][width-1:0]  b_i,
  input  logic [0:1][width-1:0]  w_i,
  output logic [0:1][width:0]    t_o,
  output logic                   clamp_o
);

  localparam int FW = 2 * width + 1;
  localparam logic signed [FW-1:0] RND = FW'(round_offset(width));

  logic signed [2*width-1:0] prod_q [4];
  logic signed [2*width-1:0] prod_d [4];
  logic [0:1][width:0]       t_q;
  logic [0:1][width:0]       t_d;
  logic                      clamp_q;
  logic                      clamp_d;
  logic                      clamp_re;
  logic                      clamp_im;

  // Returns {clamp, t}: shift by width-1 keeps the top width+2 bits, which
  // fit width+1 bits exactly when the two top bits agree.
  function automatic logic [width+1:0] round_sat(input logic signed [FW-1:0] full);
    logic [FW-1:0] r;
    r = full + RND;
    if (r[FW-1] != r[FW-2]) begin
      return {1'b1, r[FW-1], {width{~r[FW-1]}}};
    end
    return {1'b0, r[FW-2:width-1]};
  endfunction

  always_comb begin
    prod_d[0] = $signed(b_i[C_RE]) * $signed(w_i[W_RE]);
    prod_d[1] = $signed(b_i[C_IM]) * $signed(w_i[W_IM]);
    prod_d[2] = $signed(b_i[C_RE]) * $signed(w_i[W_IM]);
    prod_d[3] = $signed(b_i[C_IM]) * $signed(w_i[W_RE]);
    {clamp_re, t_d[C_RE]} = round_sat(FW'(prod_q[0]) - FW'(prod_q[1]));
    {clamp_im, t_d[C_IM]} = round_sat(FW'(prod_q[2]) + FW'(prod_q[3]));
    clamp_d = clamp_re | clamp_im;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q  <= '{default: '0};
      t_q     <= '0;
      clamp_q <= 1'b0;
    end else if (en_i) begin
      prod_q  <= prod_d;
      t_q     <= t_d;
      clamp_q <= clamp_d;
    end
  end

  assign t_o     = t_q;
  assign clamp_o = clamp_q;

endmodule

// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - 3-stage radix-2 DIT butterfly with frame clamp reporting
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi_ctr_intrf.s_axis          s_axis,
  axi_ctr_intrf.m_axis          m_axis,
  input  logic [0:3][width-1:0] data_i,
  input  logic [0:1][width-1:0] tw_i,
  output logic [0:3][width:0]   data_o,
  output logic                  frame_clamp_o
);

  if (!width_is_legal(width)) begin : g_bad_width
    $fatal(1, "fft_butterfly: width must be 8 or 16");
  end

  logic                  en;
  logic                  out_hs;
  beat_ctl_t             ctl_s1_q;
  beat_ctl_t             ctl_s2_q;
  beat_ctl_t             ctl_s3_q;
  logic [0:1][width-1:0] a_s1_q;
  logic [0:1][width-1:0] a_s2_q;
  logic [0:1][width:0]   t_s2;
  logic                  clamp_s2;
  logic                  clamp_s3_q;
  logic [0:3][width:0]   data_s3_q;
  logic [0:3][width:0]   data_s3_d;
  logic                  sticky_q;
  logic                  sticky_d;

  // One enable for the whole pipe: a bubble in S3 or a taker downstream
  assign en            = !ctl_s3_q.valid | m_axis.tready;
  assign s_axis.tready = en;
  assign out_hs        = ctl_s3_q.valid & m_axis.tready;

  fft_cmul #(.width(width)) u_cmul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en),
    .b_i     ({data_i[B_RE], data_i[B_IM]}),
    .w_i     (tw_i),
    .t_o     (t_s2),
    .clamp_o (clamp_s2)
  );

  // (a +/- t) >> 1 in width+2 bits; the halving makes the result fit width+1
  function automatic logic [width:0] half_sum(input logic [width-1:0] a,
                                              input logic [width:0]   t,
                                              input logic             sub);
    logic [width+1:0] ax;
    logic [width+1:0] tx;
    logic [width+1:0] s;
    ax = {{2{a[width-1]}}, a};
    tx = {t[width], t};
    s  = sub ? (ax - tx) : (ax + tx);
    return s[width+1:1];
  endfunction

  always_comb begin
    data_s3_d[X_RE] = half_sum(a_s2_q[C_RE], t_s2[C_RE], 1'b0);
    data_s3_d[X_IM] = half_sum(a_s2_q[C_IM], t_s2[C_IM], 1'b0);
    data_s3_d[Y_RE] = half_sum(a_s2_q[C_RE], t_s2[C_RE], 1'b1);
    data_s3_d[Y_IM] = half_sum(a_s2_q[C_IM], t_s2[C_IM], 1'b1);

    // A clamp on the tlast beat belongs to the closing frame, reported via the OR below
    sticky_d = sticky_q;
    if (out_hs) begin
      sticky_d = ctl_s3_q.last ? 1'b0 : (sticky_q | clamp_s3_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctl_s1_q   <= '0;
      ctl_s2_q   <= '0;
      ctl_s3_q   <= '0;
      a_s1_q     <= '0;
      a_s2_q     <= '0;
      clamp_s3_q <= 1'b0;
      data_s3_q  <= '0;
      sticky_q   <= 1'b0;
    end else begin
      if (en) begin
        ctl_s1_q.valid <= s_axis.tvalid;
        ctl_s1_q.last  <= s_axis.tvalid & s_axis.tlast;
        a_s1_q[C_RE]   <= data_i[A_RE];
        a_s1_q[C_IM]   <= data_i[A_IM];
        ctl_s2_q       <= ctl_s1_q;
        a_s2_q         <= a_s1_q;
        ctl_s3_q       <= ctl_s2_q;
        clamp_s3_q     <= clamp_s2;
        data_s3_q      <= data_s3_d;
      end
      sticky_q <= sticky_d;
    end
  end

  assign m_axis.tvalid = ctl_s3_q.valid;
  assign m_axis.tlast  = ctl_s3_q.last;
  assign data_o        = data_s3_q;
  assign frame_clamp_o = ctl_s3_q.valid & ctl_s3_q.last & (sticky_q | clamp_s3_q);

endmodule
